// File: rtl/rs_forney_pkg.sv
// Shared GF(256) constants, FSM state encoding and the combinational GF multiplier
// used by the Forney error-magnitude block.
package rs_forney_pkg;

    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] GF_POLY = 8'h1D;
    localparam int INV_CYCLES = 8;
    localparam int CNT_W = $clog2(INV_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        CHK,
        INV1,
        MUL1,
        INV2,
        MUL2,
        FIN
    } state_t;

    // Shift-and-add multiply over GF(2^8) with x^8 folded back as GF_POLY.
    function automatic logic [DATA_W-1:0] gf256mul(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] p;
        logic [DATA_W-1:0] sh;
        p  = '0;
        sh = a;
        for (int i = 0; i < DATA_W; i++) begin
            if (b[i]) begin
                p = p ^ sh;
            end
            sh = sh[DATA_W-1] ? ({sh[DATA_W-2:0], 1'b0} ^ GF_POLY) : {sh[DATA_W-2:0], 1'b0};
        end
        return p;
    endfunction

endpackage

// File: rtl/rs_forney_gf256_inv.sv
// GF(256) inverter: computes din^254 by MSB-first square-and-multiply, one exponent
// bit per clock, result on dout with valid pulsing INV_CYCLES edges after start.
module gf256_inv
    import rs_forney_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              valid
);

    localparam logic [DATA_W-1:0] EXP = 8'hFE;

    logic              busy;
    logic [CNT_W-1:0]  bit_idx;
    logic [DATA_W-1:0] base_p0;
    logic [DATA_W-1:0] acc_p0;
    logic [DATA_W-1:0] sq;

    assign sq   = gf256mul(acc_p0, acc_p0);
    assign dout = acc_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            valid   <= 1'b0;
            bit_idx <= '0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                busy    <= 1'b1;
                bit_idx <= CNT_W'(INV_CYCLES - 1);
            end else if (busy) begin
                if (bit_idx == '0) begin
                    busy  <= 1'b0;
                    valid <= 1'b1;
                end else begin
                    bit_idx <= bit_idx - 1'b1;
                end
            end
        end
    end

    // stage p0: accumulator holds din^(leading exponent bits processed so far)
    always_ff @(posedge clk) begin
        if (start) begin
            base_p0 <= din;
            acc_p0  <= 8'h01;
        end else if (busy) begin
            acc_p0 <= EXP[bit_idx] ? gf256mul(sq, base_p0) : sq;
        end
    end

endmodule

// File: rtl/rs_forney.sv
// Forney error-magnitude evaluator for up to two errors over GF(256), with an
// in-line byte stream corrector that applies the magnitudes once they are ready.
module rs_forney
    import rs_forney_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        error_num,
    input  logic [DATA_W-1:0] s1,
    input  logic [DATA_W-1:0] s2,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] el1,
    input  logic [DATA_W-1:0] el2,
    input  logic              byte_in_valid,
    input  logic [DATA_W-1:0] byte_in,
    output logic              byte_out_valid,
    output logic [DATA_W-1:0] byte_out,
    output logic [DATA_W-1:0] err_val1,
    output logic [DATA_W-1:0] err_val2,
    output logic              done,
    output logic              fail
);

    state_t            state;
    state_t            state_n;
    logic              chk_ph;
    logic [CNT_W-1:0]  inv_cnt;
    logic              inv_last;
    logic              done_seen;
    logic [DATA_W-1:0] idx;

    logic [1:0]        en_p0;
    logic [DATA_W-1:0] s1_p0, s2_p0, x1_p0, x2_p0, el1_p0, el2_p0;
    logic [DATA_W-1:0] den1_p1, den2_p1;

    logic [DATA_W-1:0] sx, den1_c, den2_c, num1, num2, y1, y2, mask;
    logic              chk_fail, mul1_ok, mul2_ok, corr_en;

    logic              inv_start;
    logic [DATA_W-1:0] inv_din;
    logic [DATA_W-1:0] inv_dout;
    logic              inv_valid;

    gf256_inv u_inv (
        .clk   (clk),
        .rst   (rst),
        .start (inv_start),
        .din   (inv_din),
        .dout  (inv_dout),
        .valid (inv_valid)
    );

    assign sx       = x1_p0 ^ x2_p0;
    assign den1_c   = (en_p0 == 2'd1) ? x1_p0 : gf256mul(x1_p0, sx);
    assign den2_c   = gf256mul(x2_p0, sx);
    assign num1     = (en_p0 == 2'd1) ? s1_p0 : (gf256mul(s1_p0, x2_p0) ^ s2_p0);
    assign num2     = gf256mul(s1_p0, x1_p0) ^ s2_p0;
    assign y1       = gf256mul(num1, inv_dout);
    assign y2       = gf256mul(num2, inv_dout);
    assign chk_fail = (en_p0 == 2'd3)
                   || (en_p0 != 2'd0 && x1_p0 == '0)
                   || (en_p0 == 2'd2 && (x2_p0 == '0 || x1_p0 == x2_p0));

    assign inv_last  = (inv_cnt == CNT_W'(INV_CYCLES - 1));
    assign inv_start = (state == CHK && chk_ph) || (state == MUL1 && en_p0 == 2'd2);
    assign inv_din   = (state == CHK) ? den1_p1 : den2_p1;
    assign mul1_ok   = (state == MUL1) && inv_valid;
    assign mul2_ok   = (state == MUL2) && inv_valid;
    assign corr_en   = done_seen && !fail && !start;

    always_comb begin
        mask = '0;
        if (corr_en && en_p0 != 2'd0 && idx == el1_p0) begin
            mask = mask ^ err_val1;
        end
        if (corr_en && en_p0 == 2'd2 && idx == el2_p0) begin
            mask = mask ^ err_val2;
        end
    end

    // CHK spends a second cycle on the compute path so the denominators are
    // registered before they feed the inverter.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = IDLE;
            CHK: begin
                if (chk_fail || en_p0 == 2'd0) begin
                    state_n = FIN;
                end else if (chk_ph) begin
                    state_n = INV1;
                end
            end
            INV1:    if (inv_last) state_n = MUL1;
            MUL1:    state_n = (en_p0 == 2'd2) ? INV2 : FIN;
            INV2:    if (inv_last) state_n = MUL2;
            MUL2:    state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (start) begin
            state_n = CHK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            chk_ph         <= 1'b0;
            inv_cnt        <= '0;
            done           <= 1'b0;
            fail           <= 1'b0;
            done_seen      <= 1'b0;
            err_val1       <= '0;
            err_val2       <= '0;
            idx            <= '0;
            byte_out_valid <= 1'b0;
            byte_out       <= '0;
        end else begin
            state  <= state_n;
            chk_ph <= !start && state == CHK && !chk_ph;
            done   <= !start && state == FIN;
            if ((state == INV1 || state == INV2) && state_n == state) begin
                inv_cnt <= inv_cnt + 1'b1;
            end else begin
                inv_cnt <= '0;
            end

            if (start) begin
                fail      <= 1'b0;
                done_seen <= 1'b0;
                err_val1  <= '0;
                err_val2  <= '0;
            end else begin
                if (state == CHK && !chk_ph && chk_fail) begin
                    fail <= 1'b1;
                end
                if ((mul1_ok && y1 == '0) || (mul2_ok && y2 == '0)) begin
                    fail <= 1'b1;
                end
                if (state == FIN) begin
                    done_seen <= 1'b1;
                end
                if (mul1_ok) begin
                    err_val1 <= y1;
                end
                if (mul2_ok) begin
                    err_val2 <= y2;
                end
            end

            if (start) begin
                idx <= byte_in_valid ? 8'd1 : 8'd0;
            end else if (byte_in_valid && idx != 8'hFF) begin
                idx <= idx + 1'b1;
            end

            // stage p1: corrected byte, one cycle behind byte_in
            byte_out_valid <= byte_in_valid;
            byte_out       <= byte_in ^ mask;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            en_p0  <= error_num;
            s1_p0  <= s1;
            s2_p0  <= s2;
            x1_p0  <= x1;
            x2_p0  <= x2;
            el1_p0 <= el1;
            el2_p0 <= el2;
        end
        if (state == CHK && !chk_ph) begin
            den1_p1 <= den1_c;
            den2_p1 <= den2_c;
        end
    end

endmodule

// File: tb/tb_rs_forney.sv
// Directed bench for rs_forney: latency, magnitudes, stream correction, fail paths,
// restart, reset and index saturation.
module tb_rs_forney;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] error_num;
    logic [7:0] s1, s2, x1, x2, el1, el2;
    logic       byte_in_valid;
    logic [7:0] byte_in;
    logic       byte_out_valid;
    logic [7:0] byte_out;
    logic [7:0] err_val1, err_val2;
    logic       done;
    logic       fail;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;

    localparam logic [1:0] F_EN [5] = '{2'd2, 2'd3, 2'd1, 2'd2, 2'd1};
    localparam logic [7:0] F_X1 [5] = '{8'h10, 8'h02, 8'h00, 8'h02, 8'h02};
    localparam logic [7:0] F_X2 [5] = '{8'h10, 8'h04, 8'h00, 8'h00, 8'h00};
    localparam logic [7:0] F_S1 [5] = '{8'h33, 8'h06, 8'h06, 8'h06, 8'h00};
    localparam logic [7:0] F_S2 [5] = '{8'h44, 8'h24, 8'h0C, 8'h24, 8'h00};
    localparam int         F_DE [5] = '{2, 2, 2, 2, 12};

    rs_forney dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .error_num      (error_num),
        .s1             (s1),
        .s2             (s2),
        .x1             (x1),
        .x2             (x2),
        .el1            (el1),
        .el2            (el2),
        .byte_in_valid  (byte_in_valid),
        .byte_in        (byte_in),
        .byte_out_valid (byte_out_valid),
        .byte_out       (byte_out),
        .err_val1       (err_val1),
        .err_val2       (err_val2),
        .done           (done),
        .fail           (fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents a word on the start edge, then scrambles the inputs so any late sampling shows up.
    task automatic pulse_start(input logic [1:0] en, input logic [7:0] a1, input logic [7:0] a2,
                               input logic [7:0] b1, input logic [7:0] b2,
                               input logic [7:0] e1, input logic [7:0] e2, output int c);
        error_num = en; s1 = a1; s2 = a2; x1 = b1; x2 = b2; el1 = e1; el2 = e2;
        start = 1'b1;
        tick();
        start = 1'b0;
        error_num = 2'd3; s1 = 8'hFF; s2 = 8'hEE; x1 = 8'h00; x2 = 8'h00; el1 = 8'hAA; el2 = 8'hAA;
        c = cyc;
    endtask

    task automatic wait_done(input int c0, output int de);
        de = -1;
        for (int i = 0; i < 40 && de < 0; i++) begin
            tick();
            if (done === 1'b1) de = cyc - c0;
        end
    endtask

    task automatic push(input logic [7:0] b, output logic [7:0] got, output logic gv);
        byte_in_valid = 1'b1;
        byte_in = b;
        tick();
        got = byte_out;
        gv  = byte_out_valid;
        byte_in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; error_num = 2'd0;
        s1 = 8'h00; s2 = 8'h00; x1 = 8'h00; x2 = 8'h00; el1 = 8'h00; el2 = 8'h00;
        byte_in_valid = 1'b1; byte_in = 8'hC3;
        tick(); tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL reset_fail: got %b want 0", fail); end
        total++; if (err_val1 !== 8'h00 || err_val2 !== 8'h00) begin
            bad++; $display("FAIL reset_errval: got %h/%h want 00/00", err_val1, err_val2);
        end
        total++; if (byte_out_valid !== 1'b0 || byte_out !== 8'h00) begin
            bad++; $display("FAIL reset_stream: got v=%b d=%h want v=0 d=00", byte_out_valid, byte_out);
        end
        rst = 1'b0; start = 1'b0; byte_in_valid = 1'b0;
        repeat (6) tick();
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL reset_over_start: got %0d done pulses want 0", done_cnt); end
    endtask

    task automatic test_zero_err;
        int c0, de; logic [7:0] got; logic gv;
        pulse_start(2'd0, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, c0);
        wait_done(c0, de);
        total++; if (de != 2) begin bad++; $display("FAIL zero_done_edge: got %0d want 2", de); end
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL zero_fail: got %b want 0", fail); end
        total++; if (err_val1 !== 8'h00 || err_val2 !== 8'h00) begin
            bad++; $display("FAIL zero_errval: got %h/%h want 00/00", err_val1, err_val2);
        end
        push(8'h5A, got, gv);
        total++; if (gv !== 1'b1 || got !== 8'h5A) begin
            bad++; $display("FAIL zero_stream: got v=%b d=%h want v=1 d=5a", gv, got);
        end
    endtask

    task automatic test_one_err;
        int c0, de; logic [7:0] got, exp; logic gv;
        pulse_start(2'd1, 8'h06, 8'h0C, 8'h02, 8'h00, 8'd5, 8'd2, c0);
        wait_done(c0, de);
        total++; if (de != 12) begin bad++; $display("FAIL one_done_edge: got %0d want 12", de); end
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL one_fail: got %b want 0", fail); end
        total++; if (err_val1 !== 8'h03 || err_val2 !== 8'h00) begin
            bad++; $display("FAIL one_errval: got %h/%h want 03/00", err_val1, err_val2);
        end
        for (int i = 0; i < 8; i++) begin
            exp = 8'h40 + 8'(i);
            push(exp, got, gv);
            if (i == 5) exp = exp ^ 8'h03;
            total++; if (gv !== 1'b1 || got !== exp) begin
                bad++; $display("FAIL one_stream[%0d]: got v=%b d=%h want v=1 d=%h", i, gv, got, exp);
            end
        end
    endtask

    task automatic test_two_err;
        int c0, de; logic [7:0] got, exp; logic gv;
        // X1=02 X2=04 Y1=05 Y2=03 -> S1=06 S2=24; start and byte 0 share an edge
        byte_in_valid = 1'b1; byte_in = 8'h20;
        pulse_start(2'd2, 8'h06, 8'h24, 8'h02, 8'h04, 8'd1, 8'd6, c0);
        byte_in_valid = 1'b0;
        total++; if (byte_out_valid !== 1'b1 || byte_out !== 8'h20) begin
            bad++; $display("FAIL two_start_byte: got v=%b d=%h want v=1 d=20", byte_out_valid, byte_out);
        end
        for (int i = 1; i < 3; i++) begin
            push(8'h20 + 8'(i), got, gv);
            total++; if (got !== 8'h20 + 8'(i)) begin
                bad++; $display("FAIL two_pre_done[%0d]: got %h want %h", i, got, 8'h20 + 8'(i));
            end
        end
        wait_done(c0, de);
        total++; if (de != 21) begin bad++; $display("FAIL two_done_edge: got %0d want 21", de); end
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL two_fail: got %b want 0", fail); end
        total++; if (err_val1 !== 8'h05 || err_val2 !== 8'h03) begin
            bad++; $display("FAIL two_errval_a: got %h/%h want 05/03", err_val1, err_val2);
        end
        for (int i = 3; i < 8; i++) begin
            exp = 8'h20 + 8'(i);
            push(exp, got, gv);
            if (i == 6) exp = exp ^ 8'h03;
            total++; if (gv !== 1'b1 || got !== exp) begin
                bad++; $display("FAIL two_stream_a[%0d]: got v=%b d=%h want v=1 d=%h", i, gv, got, exp);
            end
        end
        // X1=01 X2=08 Y1=07 Y2=02 -> S1=17 S2=87
        pulse_start(2'd2, 8'h17, 8'h87, 8'h01, 8'h08, 8'd0, 8'd2, c0);
        wait_done(c0, de);
        total++; if (de != 21) begin bad++; $display("FAIL two_done_edge_b: got %0d want 21", de); end
        total++; if (err_val1 !== 8'h07 || err_val2 !== 8'h02) begin
            bad++; $display("FAIL two_errval_b: got %h/%h want 07/02", err_val1, err_val2);
        end
        for (int i = 0; i < 3; i++) begin
            exp = 8'h90 + 8'(i);
            push(exp, got, gv);
            if (i == 0) exp = exp ^ 8'h07;
            if (i == 2) exp = exp ^ 8'h02;
            total++; if (got !== exp) begin
                bad++; $display("FAIL two_stream_b[%0d]: got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_fail_cases;
        int c0, de; logic [7:0] got; logic gv;
        for (int k = 0; k < 5; k++) begin
            pulse_start(F_EN[k], F_S1[k], F_S2[k], F_X1[k], F_X2[k], 8'd0, 8'd0, c0);
            wait_done(c0, de);
            total++; if (de != F_DE[k]) begin bad++; $display("FAIL fail_done_edge[%0d]: got %0d want %0d", k, de, F_DE[k]); end
            total++; if (fail !== 1'b1) begin bad++; $display("FAIL fail_flag[%0d]: got %b want 1", k, fail); end
            total++; if (err_val1 !== 8'h00 || err_val2 !== 8'h00) begin
                bad++; $display("FAIL fail_errval[%0d]: got %h/%h want 00/00", k, err_val1, err_val2);
            end
            push(8'h77, got, gv);
            total++; if (gv !== 1'b1 || got !== 8'h77) begin
                bad++; $display("FAIL fail_stream[%0d]: got v=%b d=%h want v=1 d=77", k, gv, got);
            end
            total++; if (fail !== 1'b1) begin bad++; $display("FAIL fail_held[%0d]: got %b want 1", k, fail); end
        end
    endtask

    task automatic test_restart;
        int c0, c1, de, mark;
        mark = done_cnt;
        pulse_start(2'd2, 8'h06, 8'h24, 8'h02, 8'h04, 8'd1, 8'd6, c0);
        repeat (12) tick();
        pulse_start(2'd1, 8'h06, 8'h0C, 8'h02, 8'h00, 8'd5, 8'd2, c1);
        wait_done(c1, de);
        total++; if (de != 12) begin bad++; $display("FAIL restart_done_edge: got %0d want 12", de); end
        total++; if (err_val1 !== 8'h03 || err_val2 !== 8'h00) begin
            bad++; $display("FAIL restart_errval: got %h/%h want 03/00", err_val1, err_val2);
        end
        repeat (15) tick();
        total++; if (done_cnt - mark != 1) begin
            bad++; $display("FAIL restart_done_count: got %0d want 1", done_cnt - mark);
        end
    endtask

    task automatic test_reset_mid;
        int c0, mark;
        mark = done_cnt;
        pulse_start(2'd1, 8'h06, 8'h0C, 8'h02, 8'h00, 8'd5, 8'd2, c0);
        repeat (3) tick();
        rst = 1'b1; byte_in_valid = 1'b1; byte_in = 8'hFF;
        tick();
        total++; if (byte_out_valid !== 1'b0 || byte_out !== 8'h00 || done !== 1'b0 || fail !== 1'b0
                     || err_val1 !== 8'h00 || err_val2 !== 8'h00) begin
            bad++; $display("FAIL rstmid_outputs: got v=%b d=%h done=%b fail=%b e=%h/%h want all 0",
                            byte_out_valid, byte_out, done, fail, err_val1, err_val2);
        end
        rst = 1'b0; byte_in_valid = 1'b0;
        repeat (20) tick();
        total++; if (done_cnt !== mark) begin bad++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - mark); end
    endtask

    task automatic test_saturation;
        int c0, de; logic [7:0] got, exp; logic gv;
        pulse_start(2'd1, 8'h06, 8'h0C, 8'h02, 8'h00, 8'd255, 8'd0, c0);
        wait_done(c0, de);
        total++; if (de != 12) begin bad++; $display("FAIL sat_done_edge: got %0d want 12", de); end
        for (int i = 0; i < 260; i++) begin
            exp = 8'(i) ^ 8'h5A;
            push(exp, got, gv);
            if (i >= 255) exp = exp ^ 8'h03;
            total++; if (got !== exp) begin
                bad++; $display("FAIL sat_stream[%0d]: got %h want %h", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_err();
        test_one_err();
        test_two_err();
        test_fail_cases();
        test_restart();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
